// File: rtl/cpu_ctrl_fsm_if.sv
// Control bundle between the multi-cycle CPU controller (master) and the lab datapath (slave).
interface cpu_ctrl_fsm_if #(
  parameter int OP_W = 4
);
  logic            execute;
  logic            step_mode;
  logic [OP_W-1:0] operation;
  logic            _Extern, Gout, Ain, Gin, Din, RdX, RdY, WrX;
  logic            add_sub, rf_select, sw_select;
  logic            pc_en, ir_en, MemWr, AddrSel;
  logic [3:0]      cur_state;
  logic            halted, busy;

  modport master (
    input  execute, step_mode, operation,
    output _Extern, Gout, Ain, Gin, Din, RdX, RdY, WrX,
    output add_sub, rf_select, sw_select,
    output pc_en, ir_en, MemWr, AddrSel,
    output cur_state, halted, busy
  );

  modport slave (
    output execute, step_mode, operation,
    input  _Extern, Gout, Ain, Gin, Din, RdX, RdY, WrX,
    input  add_sub, rf_select, sw_select,
    input  pc_en, ir_en, MemWr, AddrSel,
    input  cur_state, halted, busy
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle lab CPU controller with memory wait states, LD/ST sequencing, HALT and run/step.
// Define CTRL_STEP_EN to honour step_mode; otherwise the FSM runs continuously while execute=1.
module cpu_ctrl_fsm #(
  parameter int              OP_W    = 4,
  parameter int              MEM_LAT = 1,
  parameter logic [OP_W-1:0] HALT_OP = {OP_W{1'b1}}
) (
  input  logic           clk,
  input  logic           rst,
  cpu_ctrl_fsm_if.master ctrl
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_FWAIT  = 4'd2,
    S_DECODE = 4'd3,
    S_EXEC   = 4'd4,
    S_WB     = 4'd5,
    S_MADDR  = 4'd6,
    S_MWAIT  = 4'd7,
    S_MWB    = 4'd8,
    S_MST    = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUBI = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MOV  = OP_W'(6);

  localparam bit                HAS_WAIT = (MEM_LAT > 0);
  localparam int                CNT_W    = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = (MEM_LAT > 0) ? CNT_W'(MEM_LAT - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op;
  logic             step_eff;
  logic             is_halt, is_alu, is_ld, is_st;
  logic             wait_last, end_go;

  assign op = ctrl.operation;

`ifdef CTRL_STEP_EN
  assign step_eff = ctrl.step_mode;
`else
  logic unused_step;
  assign unused_step = ctrl.step_mode;
  assign step_eff    = 1'b0;
`endif

  // HALT_OP wins over every other decode so a parameter collision still halts.
  assign is_halt   = (op == HALT_OP);
  assign is_alu    = !is_halt && ((op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) ||
                                  (op == OP_SUBI) || (op == OP_MOV));
  assign is_ld     = !is_halt && (op == OP_LD);
  assign is_st     = !is_halt && (op == OP_ST);
  assign wait_last = (cnt_q == '0);
  assign end_go    = ctrl.execute && !step_eff;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ctrl._Extern   = 1'b1;
    ctrl.Gout      = 1'b0;
    ctrl.Ain       = 1'b0;
    ctrl.Gin       = 1'b0;
    ctrl.Din       = 1'b0;
    ctrl.RdX       = 1'b0;
    ctrl.RdY       = 1'b0;
    ctrl.WrX       = 1'b0;
    ctrl.add_sub   = 1'b0;
    ctrl.rf_select = 1'b0;
    ctrl.sw_select = 1'b0;
    ctrl.pc_en     = 1'b0;
    ctrl.ir_en     = 1'b0;
    ctrl.MemWr     = 1'b0;
    ctrl.AddrSel   = 1'b0;
    ctrl.halted    = 1'b0;
    ctrl.cur_state = state_q;
    ctrl.busy      = (state_q != S_IDLE) && (state_q != S_HALT);

    unique case (state_q)
      S_IDLE: begin
        if (ctrl.execute) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (HAS_WAIT) begin
          state_d = S_FWAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          ctrl.ir_en = 1'b1;
          ctrl.pc_en = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_FWAIT: begin
        if (wait_last) begin
          ctrl.ir_en = 1'b1;
          ctrl.pc_en = 1'b1;
          state_d    = S_DECODE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DECODE: begin
        ctrl.RdX = 1'b1;
        ctrl.RdY = 1'b1;
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_alu) begin
          ctrl.Ain = 1'b1;
          state_d  = S_EXEC;
        end else if (is_ld || is_st) begin
          state_d = S_MADDR;
        end else begin
          state_d = end_go ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC: begin
        ctrl.Gin       = 1'b1;
        ctrl.add_sub   = (op == OP_SUB) || (op == OP_SUBI);
        ctrl.rf_select = (op == OP_ADD) || (op == OP_SUB);
        ctrl.sw_select = (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_MOV);
        state_d        = S_WB;
      end
      S_WB: begin
        ctrl.Gout = 1'b1;
        ctrl.WrX  = 1'b1;
        state_d   = end_go ? S_FETCH : S_IDLE;
      end
      S_MADDR: begin
        ctrl.AddrSel = 1'b1;
        ctrl.RdX     = 1'b1;
        ctrl.RdY     = 1'b1;
        ctrl.Din     = is_st;
        if (HAS_WAIT) begin
          state_d = S_MWAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = is_st ? S_MST : S_MWB;
        end
      end
      S_MWAIT: begin
        ctrl.AddrSel = 1'b1;
        if (wait_last) state_d = is_st ? S_MST : S_MWB;
        else           cnt_d   = cnt_q - 1'b1;
      end
      S_MWB: begin
        ctrl.AddrSel = 1'b1;
        ctrl._Extern = 1'b0;
        ctrl.WrX     = 1'b1;
        state_d      = end_go ? S_FETCH : S_IDLE;
      end
      S_MST: begin
        ctrl.AddrSel = 1'b1;
        ctrl.MemWr   = 1'b1;
        state_d      = end_go ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomized bench for cpu_ctrl_fsm: three instances (MEM_LAT 0,1,2) against an instruction-level plan model.
module tb_cpu_ctrl_fsm;
  localparam int NI = 3;
  localparam int FLAG = 16;
  localparam int IDLE = 0, FETCH = 1, FWAIT = 2, DECODE = 3, EXEC = 4, WB = 5;
  localparam int MADDR = 6, MWAIT = 7, MWB = 8, MST = 9, HALT = 10;
  localparam int NCYC = 3000;

  logic       clk = 1'b0;
  logic       rst, execute, step_mode;
  logic [3:0] ir [NI];

  logic [16:0] obs_ctrl [NI];
  logic [3:0]  obs_st   [NI];

  int n_tests = 0;
  int n_fail  = 0;

  int         exp_st   [NI];
  int         plan     [NI][16];
  int         plan_len [NI];
  int         plan_pos [NI];
  logic [3:0] plan_op  [NI];
  bit         in_instr [NI];
  bit         ir_load  [NI];
  int         prog_idx [NI];
  int         fetch_exp[NI];
  int         fetch_obs[NI];
  bit         did_mw_rst;
  logic [3:0] dir_prog [8] = '{4'd0, 4'd4, 4'd5, 4'd6, 4'd9, 4'd1, 4'd2, 4'd3};

  always #5 clk = ~clk;

  cpu_ctrl_fsm_if #(.OP_W(4)) if0 ();
  cpu_ctrl_fsm_if #(.OP_W(4)) if1 ();
  cpu_ctrl_fsm_if #(.OP_W(4)) if2 ();

  assign if0.execute = execute;  assign if0.step_mode = step_mode;  assign if0.operation = ir[0];
  assign if1.execute = execute;  assign if1.step_mode = step_mode;  assign if1.operation = ir[1];
  assign if2.execute = execute;  assign if2.step_mode = step_mode;  assign if2.operation = ir[2];

  cpu_ctrl_fsm #(.OP_W(4), .MEM_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .ctrl(if0));
  cpu_ctrl_fsm #(.OP_W(4), .MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .ctrl(if1));
  cpu_ctrl_fsm #(.OP_W(4), .MEM_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .ctrl(if2));

  assign obs_ctrl[0] = {if0._Extern, if0.Gout, if0.Ain, if0.Gin, if0.Din, if0.RdX, if0.RdY, if0.WrX,
                        if0.add_sub, if0.rf_select, if0.sw_select, if0.pc_en, if0.ir_en, if0.MemWr,
                        if0.AddrSel, if0.halted, if0.busy};
  assign obs_ctrl[1] = {if1._Extern, if1.Gout, if1.Ain, if1.Gin, if1.Din, if1.RdX, if1.RdY, if1.WrX,
                        if1.add_sub, if1.rf_select, if1.sw_select, if1.pc_en, if1.ir_en, if1.MemWr,
                        if1.AddrSel, if1.halted, if1.busy};
  assign obs_ctrl[2] = {if2._Extern, if2.Gout, if2.Ain, if2.Gin, if2.Din, if2.RdX, if2.RdY, if2.WrX,
                        if2.add_sub, if2.rf_select, if2.sw_select, if2.pc_en, if2.ir_en, if2.MemWr,
                        if2.AddrSel, if2.halted, if2.busy};
  assign obs_st[0] = if0.cur_state;
  assign obs_st[1] = if1.cur_state;
  assign obs_st[2] = if2.cur_state;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit step_eff(input logic sm);
`ifdef CTRL_STEP_EN
    return sm;
`else
    return 1'b0;
`endif
  endfunction

  // Control pattern each state/opcode pair must show, read straight off the state descriptions.
  function automatic logic [16:0] exp_ctrl(input int st, input logic [3:0] op, input bit ff);
    bit alu, ld_st;
    alu   = (op != 4'd15) && ((op <= 4'd3) || (op == 4'd6));
    ld_st = (op == 4'd4) || (op == 4'd5);
    return {st != MWB,
            st == WB,
            (st == DECODE) && alu,
            st == EXEC,
            (st == MADDR) && (op == 4'd5),
            (st == DECODE) || (st == MADDR),
            (st == DECODE) || (st == MADDR),
            (st == WB) || (st == MWB),
            (st == EXEC) && ((op == 4'd1) || (op == 4'd3)),
            (st == EXEC) && (op <= 4'd1),
            (st == EXEC) && ((op == 4'd2) || (op == 4'd3) || (op == 4'd6)),
            ff,
            ff,
            st == MST,
            (st == MADDR) || (st == MWAIT) || (st == MWB) || (st == MST) || (ld_st && 1'b0),
            st == HALT,
            (st != IDLE) && (st != HALT)};
  endfunction

  // Whole instruction laid out as a state list; FLAG marks the cycle that completes the fetch.
  task automatic build_plan(input int k);
    logic [3:0] op;
    int n;
    if (prog_idx[k] < 8) op = dir_prog[prog_idx[k]];
    else if ($urandom_range(0, 11) == 0) op = 4'd15;
    else op = 4'($urandom_range(0, 14));
    prog_idx[k]++;
    n = 0;
    if (k == 0) begin
      plan[k][n++] = FETCH + FLAG;
    end else begin
      plan[k][n++] = FETCH;
      for (int i = 0; i < k; i++) plan[k][n++] = FWAIT + ((i == k - 1) ? FLAG : 0);
    end
    plan[k][n++] = DECODE;
    if (op == 4'd15) begin
      plan[k][n++] = HALT;
    end else if ((op <= 4'd3) || (op == 4'd6)) begin
      plan[k][n++] = EXEC;
      plan[k][n++] = WB;
    end else if ((op == 4'd4) || (op == 4'd5)) begin
      plan[k][n++] = MADDR;
      for (int i = 0; i < k; i++) plan[k][n++] = MWAIT;
      plan[k][n++] = (op == 4'd5) ? MST : MWB;
    end
    plan_len[k] = n;
    plan_pos[k] = 0;
    plan_op[k]  = op;
    in_instr[k] = 1'b1;
    exp_st[k]   = plan[k][0] % FLAG;
  endtask

  task automatic advance(input int k);
    if (in_instr[k] && (plan[k][plan_pos[k]] >= FLAG) && rst) ir_load[k] = 1'b1;
    if (!rst) begin
      exp_st[k]   = IDLE;
      in_instr[k] = 1'b0;
    end else if (exp_st[k] == HALT) begin
      exp_st[k] = HALT;
    end else if (!in_instr[k]) begin
      if (execute) build_plan(k);
    end else begin
      plan_pos[k]++;
      if (plan_pos[k] < plan_len[k]) begin
        exp_st[k] = plan[k][plan_pos[k]] % FLAG;
      end else if (execute && !step_eff(step_mode)) begin
        build_plan(k);
      end else begin
        exp_st[k]   = IDLE;
        in_instr[k] = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b0; execute = 1'b0; step_mode = 1'b0; did_mw_rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      ir[k] = 4'd0; exp_st[k] = IDLE; in_instr[k] = 1'b0; ir_load[k] = 1'b0;
      prog_idx[k] = 0; fetch_exp[k] = 0; fetch_obs[k] = 0; plan_len[k] = 0; plan_pos[k] = 0;
      plan_op[k] = 4'd0;
    end
    repeat (2) @(posedge clk);

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        bit ff;
        logic [16:0] want;
        ff   = in_instr[k] && (plan[k][plan_pos[k]] >= FLAG);
        want = exp_ctrl(exp_st[k], plan_op[k], ff);
        chk($sformatf("state%0d", k), 32'(obs_st[k]), 32'(exp_st[k]));
        chk($sformatf("ctrl%0d", k), 32'(obs_ctrl[k]), 32'(want));
        fetch_obs[k] += int'(obs_ctrl[k][5]);
        fetch_exp[k] += int'(want[5]);
      end

      if (c < 3) begin
        rst = 1'b0; execute = 1'b0; step_mode = 1'b0;
      end else if (c < 13) begin
        rst = 1'b1; execute = 1'b0;
      end else if (c < 400) begin
        rst = 1'b1; execute = 1'b1; step_mode = 1'b0;
      end else if (c < 600) begin
        rst = (c != 400); execute = 1'b1; step_mode = 1'b1;
      end else begin
        rst       = ($urandom_range(0, 63) != 0);
        execute   = ($urandom_range(0, 7) != 0);
        step_mode = ($urandom_range(0, 3) == 0);
        if (!did_mw_rst && (exp_st[2] == MWAIT) && (plan_op[2] == 4'd5)) begin
          rst        = 1'b0;
          did_mw_rst = 1'b1;
        end
      end

      for (int k = 0; k < NI; k++) advance(k);
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
        if (ir_load[k]) ir[k] = plan_op[k];
        ir_load[k] = 1'b0;
      end
    end

    for (int k = 0; k < NI; k++) chk($sformatf("fetches%0d", k), 32'(fetch_obs[k]), 32'(fetch_exp[k]));
    chk("mwait_rst_seen", 32'(did_mw_rst), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
